// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC width, reset PC, RAS depth defaults and the next-PC select encoding
package cpu_pkg;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    localparam int RAS_DEPTH = 4;
    typedef enum logic [2:0] {SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET} pc_sel_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; clk, rst, push/pop strobes, din/dout, count, full/empty, ovf/unf strobes
module ras_stack #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    always_comb begin
        empty = count == '0;
        full = count == ($clog2(DEPTH)+1)'(DEPTH);
        ovf = push && !pop && full;
        unf = pop && empty;
        dout = mem[ptr - 1'b1];
    end
    always_ff @(posedge clk)
        if (push && !pop) mem[ptr] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            count <= '0;
        end else if (pop) begin
            if (!empty) begin
                ptr <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end else if (push) begin
            ptr <= ptr + 1'b1;
            count <= full ? count : count + 1'b1;
        end
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: PC register with priority next-PC mux and RAS; clk, rst, en, br_take, br_off_16b, jmp, call, ret, jmp_addr_16b -> pc_16b, ras_empty, ras_full, ras_err
module pc_ras_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            br_take,
    input  logic [PC_W-1:0] br_off_16b,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] jmp_addr_16b,
    output logic [PC_W-1:0] pc_16b,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);
    pc_sel_t sel;
    logic [PC_W-1:0] pc_inc, pc_nxt, ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;
    logic push, pop, ovf, unf;
    always_comb begin
        sel = ret ? SEL_RET : call ? SEL_CALL : jmp ? SEL_JMP : br_take ? SEL_BR : SEL_INC;
        push = en && sel == SEL_CALL;
        pop = en && sel == SEL_RET;
        pc_inc = pc_16b + 1'b1;
        pc_nxt = sel == SEL_RET ? (ras_cnt != '0 ? ras_top : pc_inc) :
                 (sel == SEL_CALL || sel == SEL_JMP) ? jmp_addr_16b :
                 sel == SEL_BR ? pc_16b + br_off_16b : pc_inc;
    end
    ras_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pc_inc), .dout(ras_top),
        .count(ras_cnt), .full(ras_full), .empty(ras_empty), .ovf(ovf), .unf(unf)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc_16b <= RESET_PC;
            ras_err <= 1'b0;
        end else if (en) begin
            pc_16b <= pc_nxt;
            ras_err <= ras_err | ovf | unf;
        end
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed self-checking bench for pc_ras_unit
module tb_pc_ras_unit;
    logic clk = 0, rst = 1, en = 0, br_take = 0, jmp = 0, call = 0, ret = 0;
    logic [15:0] br_off_16b = '0, jmp_addr_16b = '0, pc_16b;
    logic ras_empty, ras_full, ras_err;
    int pass = 0, total = 0;
    always #5 clk = ~clk;
    pc_ras_unit dut (
        .clk(clk), .rst(rst), .en(en), .br_take(br_take), .br_off_16b(br_off_16b),
        .jmp(jmp), .call(call), .ret(ret), .jmp_addr_16b(jmp_addr_16b),
        .pc_16b(pc_16b), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );
    function automatic logic [15:0] sext(input logic [11:0] x);
        return {{4{x[11]}}, x};
    endfunction
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic ctl(input logic r, input logic c, input logic j, input logic b, input logic [15:0] a, input logic [15:0] o);
        ret = r; call = c; jmp = j; br_take = b; jmp_addr_16b = a; br_off_16b = o;
    endtask
    task automatic go(input logic [15:0] a);
        ctl(0, 0, 1, 0, a, 0);
        step();
        ctl(0, 0, 0, 0, 0, 0);
    endtask
    task automatic chk_pc(input string nm, input logic [15:0] exp);
        total++;
        if (pc_16b !== exp) $display("FAIL %s pc=%h exp=%h", nm, pc_16b, exp);
        else pass++;
    endtask
    task automatic chk_fl(input string nm, input logic e, input logic f, input logic r);
        total++;
        if ({ras_empty, ras_full, ras_err} !== {e, f, r})
            $display("FAIL %s empty/full/err=%b%b%b exp=%b%b%b", nm, ras_empty, ras_full, ras_err, e, f, r);
        else pass++;
    endtask
    task automatic test_reset();
        @(negedge clk);
        chk_pc("reset_pc", 16'h0000);
        chk_fl("reset_flags", 1, 0, 0);
        rst = 0;
        en = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_pc($sformatf("inc%0d", i), 16'(i));
        end
        chk_fl("inc_flags", 1, 0, 0);
    endtask
    task automatic test_branch();
        go(16'h0010);
        ctl(0, 0, 0, 1, 0, sext(12'hFFE));
        step();
        chk_pc("br_neg", 16'h000E);
        go(16'h0000);
        ctl(0, 0, 0, 1, 0, sext(12'h7FF));
        step();
        chk_pc("br_pos", 16'h07FF);
        ctl(0, 0, 1, 1, 16'h4444, 16'h0010);
        step();
        chk_pc("jmp_over_br", 16'h4444);
    endtask
    task automatic test_wrap_stall();
        go(16'hFFFF);
        ctl(0, 0, 0, 0, 0, 0);
        step();
        chk_pc("wrap", 16'h0000);
        en = 0;
        ctl(0, 1, 1, 0, 16'h1234, 0);
        step();
        chk_pc("stall_pc", 16'h0000);
        chk_fl("stall_flags", 1, 0, 0);
        en = 1;
        ctl(0, 0, 1, 0, 16'h1234, 0);
        step();
        chk_pc("jmp", 16'h1234);
    endtask
    task automatic test_nested();
        go(16'h0020);
        ctl(0, 1, 0, 0, 16'h0100, 0);
        step();
        chk_pc("call1", 16'h0100);
        chk_fl("call1_flags", 0, 0, 0);
        ctl(0, 1, 0, 0, 16'h0200, 0);
        step();
        chk_pc("call2", 16'h0200);
        ctl(1, 0, 0, 0, 0, 0);
        step();
        chk_pc("ret1", 16'h0101);
        step();
        chk_pc("ret2", 16'h0021);
        chk_fl("ret2_flags", 1, 0, 0);
        ctl(0, 1, 0, 0, 16'h0300, 0);
        step();
        ctl(1, 1, 1, 1, 16'h0500, 16'h0008);
        step();
        chk_pc("ret_call", 16'h0022);
        chk_fl("ret_call_flags", 1, 0, 0);
    endtask
    task automatic test_overflow();
        logic [15:0] a [5] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000};
        go(a[0]);
        for (int i = 0; i < 5; i++) begin
            ctl(0, 1, 0, 0, a[i] + 16'h1000, 0);
            step();
            chk_pc($sformatf("ocall%0d", i), a[i] + 16'h1000);
            if (i == 3) chk_fl("full4", 0, 1, 0);
        end
        chk_fl("ovf_flags", 0, 1, 1);
        ctl(1, 0, 0, 0, 0, 0);
        for (int i = 4; i >= 1; i--) begin
            step();
            chk_pc($sformatf("oret%0d", i), a[i] + 16'h0001);
        end
        chk_fl("drained", 1, 0, 1);
        step();
        chk_pc("unf_pc", 16'h2002);
        chk_fl("unf_flags", 1, 0, 1);
        ctl(0, 0, 0, 0, 0, 0);
    endtask
    task automatic test_async_reset();
        ctl(0, 1, 0, 0, 16'h7777, 0);
        step();
        chk_pc("pre_rst_call", 16'h7777);
        chk_fl("pre_rst_flags", 0, 0, 1);
        #2 rst = 1;
        #1;
        chk_pc("async_pc", 16'h0000);
        chk_fl("async_flags", 1, 0, 0);
        step();
        chk_pc("held_rst", 16'h0000);
        rst = 0;
        ctl(0, 0, 0, 0, 0, 0);
        step();
        chk_pc("post_rst", 16'h0001);
    endtask
    initial begin
        test_reset();
        test_branch();
        test_wrap_stall();
        test_nested();
        test_overflow();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Program-counter stage of the lab processor. It sits directly downstream of the 12b-to-16b immediate sign extender and consumes its 16-bit output as the relative branch offset.
- Holds the 16-bit PC and selects the next PC from: increment, relative branch, absolute jump, call and return.
- Contains a small circular return-address stack (RAS) for call/return.
- Its registered PC output drives instruction-memory addressing.

Parameters:
- PC_W, 16, width of PC, offsets, addresses and RAS entries.
- RESET_PC, 16'h0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; 0 holds all state (stall).
- br_take  input  1  take a relative branch this cycle.
- br_off_16b  input  PC_W  sign-extended branch offset, from the sign extender's out_16b.
- jmp  input  1  absolute jump to jmp_addr_16b.
- call  input  1  push return address, then jump to jmp_addr_16b.
- ret  input  1  pop return address into the PC.
- jmp_addr_16b  input  PC_W  absolute target for jmp and call.
- pc_16b  output  PC_W  current PC, registered.
- ras_empty  output  1  RAS holds 0 entries, registered.
- ras_full  output  1  RAS holds RAS_DEPTH entries, registered.
- ras_err  output  1  sticky RAS overflow/underflow flag.

Behaviour:
- Reset (async, active-high):
  - pc_16b=RESET_PC, RAS count=0, RAS pointer=0.
  - ras_empty=1, ras_full=0, ras_err=0.
  - Reset asserted mid-operation aborts any pending update immediately, without waiting for a clock edge.
  - First update occurs on the first rising edge after rst deasserts.
- Update timing: one register stage. The PC changes on the rising edge after the control inputs are sampled. pc_16b reflects the new value in the next cycle, with no combinational path from inputs to pc_16b.
- en=0: PC, RAS contents, count and flags all hold. Control inputs are ignored.
- en=1: next-PC selection by fixed priority, highest first:
  1. ret
     - If count>0: pop; PC <= popped entry; count decrements.
     - If count==0 (underflow): PC <= PC+1; ras_err <= 1; count stays 0.
  2. call
     - Push PC+1, then PC <= jmp_addr_16b.
     - If count==RAS_DEPTH (overflow): the push overwrites the oldest entry (circular), count stays RAS_DEPTH, ras_err <= 1.
  3. jmp: PC <= jmp_addr_16b.
  4. br_take: PC <= PC + br_off_16b. The offset is relative to the current instruction's address.
  5. otherwise: PC <= PC+1.
- Simultaneous requests: lower-priority requests asserted in the same cycle are dropped entirely, with no partial side effects. Example: ret and call together pops only, with no push.
- Arithmetic:
  - All additions are PC_W-bit, modulo 2^PC_W. The carry is discarded and no overflow is flagged.
  - 16'hFFFF+1 = 16'h0000.
  - br_off_16b is treated as two's complement, so PC + 16'hFFFE = PC-2.
- RAS structure: circular buffer with top pointer; push writes at pointer then advances; pop retreats then reads. After overflow, the returnable entries are the most recent RAS_DEPTH pushes.
- Flags:
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are updated in the same edge as count.
  - ras_err is cleared only by rst.

Decomposition:
- Shared package (cpu_pkg): PC_W, RESET_PC, RAS_DEPTH defaults, and the next-PC select encoding (SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET).
- One sub-module, ras_stack:
  - Parameterised circular stack with push/pop strobes, data in/out, count, and full/empty/overflow/underflow outputs.
  - Same clk and rst.
- The top level holds the PC register and the priority mux.

Test Plan:
- Reset then increment: rst pulse, en=1 for 3 cycles, no controls -> pc_16b sequence 0x0000, 0x0001, 0x0002, 0x0003; ras_empty=1, ras_err=0.
- Negative branch via the sign extender: PC=0x0010, in_12b=12'hFFE so br_off_16b=16'hFFFE, br_take=1 -> pc_16b=0x000E next cycle. Also in_12b=12'h7FF from PC=0x0000 -> 0x07FF.
- Wrap and stall:
  - PC=0xFFFF, increment -> 0x0000.
  - en=0 with jmp=1, jmp_addr=0x1234 -> PC unchanged.
  - en=1 with jmp=1, jmp_addr=0x1234 -> 0x1234.
- Nested call/return:
  - call to 0x0100 from PC=0x0020, then call to 0x0200 from 0x0100.
  - ret -> 0x0101; ret -> 0x0021; ras_empty=1, ras_err=0.
  - Same-cycle ret+call -> pop only.
- Overflow and underflow:
  - 5 consecutive calls from PCs A0..A4 -> ras_full=1, ras_err=1.
  - 4 rets return A4+1, A3+1, A2+1, A1+1 in that order.
  - 5th ret -> PC+1, ras_err stays 1.
- Async reset mid-call: assert rst between clock edges while a call is pending -> pc_16b=0x0000 and ras_empty=1 immediately; ras_err=0.
